// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and helpers for the shift serializer
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/right_shift_stage.sv
// rtl/right_shift_stage.sv - combinational zero-fill logical right shift by S
module right_shift_stage #(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] res
);

    assign res = a >> S;

endmodule

// File: rtl/shift_serializer.sv
// rtl/shift_serializer.sv - N-bit word to S-bit chunk serializer, LSB chunk first
module shift_serializer
    import shift_pkg::*;
#(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [S-1:0] out_data,
    output logic         out_last
);

    localparam int K  = ceil_div(N, S);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

    ser_state_t    state, state_n;
    logic [N-1:0]  shreg, shreg_n, shreg_shifted;
    logic [CW-1:0] cnt, cnt_n;
    logic          beat, load;

    right_shift_stage #(.N(N), .S(S)) u_shift (
        .a   (shreg),
        .res (shreg_shifted)
    );

    assign out_valid = (state == SHIFT);
    assign out_data  = shreg[S-1:0];
    assign out_last  = (state == SHIFT) && (cnt == LAST_CNT);
    assign beat      = out_valid && out_ready;
    // Accepting during the final beat lets words stream without a bubble.
    assign in_ready  = (state == IDLE) || (beat && out_last);
    assign load      = in_valid && in_ready;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        if (load) begin
            state_n = SHIFT;
            shreg_n = in_data;
            cnt_n   = '0;
        end else if (beat) begin
            if (out_last) begin
                state_n = IDLE;
            end else begin
                shreg_n = shreg_shifted;
                cnt_n   = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_shift_serializer.sv
// tb/tb_shift_serializer.sv - directed self-checking bench for shift_serializer
module tb_shift_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // N=8, S=3
    logic       a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_out_last;
    logic [7:0] a_in_data = 0;
    logic [2:0] a_out_data;
    // N=8, S=4
    logic       b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_last;
    logic [7:0] b_in_data = 0;
    logic [3:0] b_out_data;
    // N=8, S=8
    logic       c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_out_last;
    logic [7:0] c_in_data = 0;
    logic [7:0] c_out_data;

    shift_serializer #(.N(8), .S(3)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_last(a_out_last)
    );

    shift_serializer #(.N(8), .S(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last)
    );

    shift_serializer #(.N(8), .S(8)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_last(c_out_last)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 3'd0 || a_out_last !== 1'b0 || a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_a: valid=%b data=%0d last=%b ready=%b, want 0 0 0 1",
                     a_out_valid, a_out_data, a_out_last, a_in_ready);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== 4'd0 || b_out_last !== 1'b0 || b_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_b: valid=%b data=%0d last=%b ready=%b, want 0 0 0 1",
                     b_out_valid, b_out_data, b_out_last, b_in_ready);
        end
        checks++;
        if (c_out_valid !== 1'b0 || c_out_data !== 8'd0 || c_out_last !== 1'b0 || c_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_c: valid=%b data=%0d last=%b ready=%b, want 0 0 0 1",
                     c_out_valid, c_out_data, c_out_last, c_in_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [2:0] exp_d [3] = '{3'd6, 3'd6, 3'd2};
        @(posedge clk);
        #1;
        a_in_valid = 1'b1; a_in_data = 8'hB6; a_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_pre_accept: valid=%b ready=%b, want 0 1", a_out_valid, a_in_ready);
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0; a_in_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d[i] || a_out_last !== (i == 2)) begin
                fails++;
                $display("FAIL basic_beat%0d: valid=%b data=%0d last=%b, want 1 %0d %b",
                         i, a_out_valid, a_out_data, a_out_last, exp_d[i], (i == 2));
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_idle: valid=%b ready=%b, want 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_backpressure;
        @(posedge clk);
        #1;
        a_in_valid = 1'b1; a_in_data = 8'hB6; a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_out_data !== 3'd6 || a_out_last !== 1'b0) begin
            fails++;
            $display("FAIL bp_beat0: data=%0d last=%b, want 6 0", a_out_data, a_out_last);
        end
        @(posedge clk);
        #1 a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 3'd6 || a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b data=%0d last=%b ready=%b, want 1 6 0 0",
                         i, a_out_valid, a_out_data, a_out_last, a_in_ready);
            end
            @(posedge clk);
        end
        #1 a_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_out_data !== 3'd6 || a_out_last !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: data=%0d last=%b, want 6 0", a_out_data, a_out_last);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 3'd2 || a_out_last !== 1'b1) begin
            fails++;
            $display("FAIL bp_last: valid=%b data=%0d last=%b, want 1 2 1", a_out_valid, a_out_data, a_out_last);
        end
        @(posedge clk);
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp_d [6] = '{3'd6, 3'd6, 3'd2, 3'd7, 3'd7, 3'd3};
        logic       exp_r [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        @(posedge clk);
        #1;
        a_in_valid = 1'b1; a_in_data = 8'hB6; a_out_ready = 1'b1;
        @(posedge clk);
        #1 a_in_data = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d[i] || a_out_last !== exp_r[i] || a_in_ready !== exp_r[i]) begin
                fails++;
                $display("FAIL b2b_beat%0d: valid=%b data=%0d last=%b ready=%b, want 1 %0d %b %b",
                         i, a_out_valid, a_out_data, a_out_last, a_in_ready, exp_d[i], exp_r[i], exp_r[i]);
            end
            @(posedge clk);
            if (i == 2) begin
                #1;
                a_in_valid = 1'b0; a_in_data = 8'h00;
            end
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: valid=%b, want 0", a_out_valid);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [2:0] exp_d [3] = '{3'd1, 3'd0, 3'd0};
        @(posedge clk);
        #1;
        a_in_valid = 1'b1; a_in_data = 8'hB6; a_out_ready = 1'b1;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 3'd0 || a_out_last !== 1'b0 || a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: valid=%b data=%0d last=%b ready=%b, want 0 0 0 1",
                     a_out_valid, a_out_data, a_out_last, a_in_ready);
        end
        a_in_valid = 1'b1; a_in_data = 8'h01;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0; a_in_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d[i] || a_out_last !== (i == 2)) begin
                fails++;
                $display("FAIL rst_next_beat%0d: valid=%b data=%0d last=%b, want 1 %0d %b",
                         i, a_out_valid, a_out_data, a_out_last, exp_d[i], (i == 2));
            end
            @(posedge clk);
        end
    endtask

    task automatic test_s4;
        logic [3:0] exp_d [2] = '{4'h5, 4'hA};
        @(posedge clk);
        #1;
        b_in_valid = 1'b1; b_in_data = 8'hA5; b_out_ready = 1'b1;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (b_out_valid !== 1'b1 || b_out_data !== exp_d[i] || b_out_last !== (i == 1)) begin
                fails++;
                $display("FAIL s4_beat%0d: valid=%b data=%h last=%b, want 1 %h %b",
                         i, b_out_valid, b_out_data, b_out_last, exp_d[i], (i == 1));
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL s4_idle: valid=%b, want 0", b_out_valid);
        end
    endtask

    task automatic test_s8;
        logic [7:0] exp_d [2] = '{8'h3C, 8'hC3};
        @(posedge clk);
        #1;
        c_in_valid = 1'b1; c_in_data = 8'h3C; c_out_ready = 1'b1;
        @(posedge clk);
        #1 c_in_data = 8'hC3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (c_out_valid !== 1'b1 || c_out_data !== exp_d[i] || c_out_last !== 1'b1 || c_in_ready !== 1'b1) begin
                fails++;
                $display("FAIL s8_beat%0d: valid=%b data=%h last=%b ready=%b, want 1 %h 1 1",
                         i, c_out_valid, c_out_data, c_out_last, c_in_ready, exp_d[i]);
            end
            @(posedge clk);
            #1 c_in_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL s8_idle: valid=%b ready=%b, want 0 1", c_out_valid, c_in_ready);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_word;
        test_s4;
        test_s8;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
- Parallel-in, serial-out stage. Accepts an N-bit word over a valid/ready handshake and emits it as S-bit chunks, LSB chunk first.
- Each beat is produced by a logical right shift by S of an internal register, with zero fill.
- Sits downstream of word producers and feeds narrow S-bit links; one word in, K = ceil(N/S) beats out.

Parameters:
- N, 8, input word width; N >= 1.
- S, 3, chunk width and shift amount per beat; 1 <= S <= N.
- K (localparam), (N+S-1)/S, beats per word.
- CW (localparam), max(1, $clog2(K)), beat counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  upstream word valid
- in_ready  out  1  block accepts word this cycle
- in_data  in  N  word to serialize
- out_valid  out  1  chunk valid
- out_ready  in  1  downstream accepts chunk
- out_data  out  S  current chunk
- out_last  out  1  current chunk is beat K-1 of the word

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, shreg=0, cnt=0. All register-based outputs read 0 after the edge, including out_valid, out_data and out_last. in_ready=1.
- Reset mid-word: the partially sent word is dropped, with no further beats. The next accepted word starts at beat 0.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - SHIFT: out_valid=1.
- Transitions:
  - IDLE -> SHIFT on in_valid&&in_ready. Loads shreg<=in_data, cnt<=0.
  - SHIFT, beat handshake (out_valid&&out_ready) with cnt<K-1: shreg<=shreg>>S, cnt<=cnt+1, stay in SHIFT.
  - SHIFT, handshake with cnt==K-1 and !in_valid: go to IDLE.
  - SHIFT, handshake with cnt==K-1 and in_valid: load the new word (shreg<=in_data, cnt<=0) and stay in SHIFT. No bubble; load wins over the shift.
- Outputs:
  - out_data = shreg[S-1:0].
  - out_last = (state==SHIFT)&&(cnt==K-1).
  - Both are driven from registers only.
  - in_ready = (state==IDLE) || (out_valid&&out_ready&&out_last). This is combinational from out_ready; it is the only comb path input->output.
- Latency: a word accepted at edge t gives its first beat valid in the cycle after t. Sustained throughput is one word per K cycles.
- Backpressure: while out_valid&&!out_ready, shreg, cnt, out_data and out_last hold unchanged. in_ready=0 in this case unless state is IDLE.
- N not a multiple of S: the final beat carries the top N-(K-1)*S bits in its LSBs, with the upper bits 0 from the zero-fill shift.
- S==N: K=1. Every beat has out_last=1, and back-to-back words stream at one per cycle.
- in_data and in_valid are ignored unless in_ready is high.
- No X propagation: all registers are reset.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic {IDLE, SHIFT} ser_state_t
  - function ceil_div(a,b) used to compute K
- Sub-module right_shift_stage #(N,S): purely combinational, res = a >> S with zero fill. Instantiated once to produce the next shreg value.
- Counter, FSM and handshake logic live in shift_serializer.

Test Plan:
- Basic (N=8,S=3): in_data=8'hB6 with out_ready=1. Beats out_data=3'd6,3'd6,3'd2 on consecutive cycles; out_last=0,0,1. The first beat appears the cycle after acceptance.
- Backpressure: same word, out_ready=0 for 3 cycles on beat 2. out_data holds 3'd6, out_last=0 and in_ready=0 throughout. Beat 3'd2 with last=1 follows after release.
- Back-to-back: 8'hB6 then 8'hFF, in_valid held and out_ready=1. Beats are 6,6,2,7,7,3 with no idle cycle; in_ready=1 exactly on the cycle of the first word's last beat.
- Reset mid-word: rst_n=0 for one edge after beat 1 of 8'hB6. Next cycle out_valid=0, out_data=0, in_ready=1. A following word 8'h01 emits 1,0,0.
- Parameter N=8,S=4: in_data=8'hA5 gives beats 4'h5 (last=0), then 4'hA (last=1).
- Parameter N=8,S=8: words 8'h3C,8'hC3 streamed back-to-back give one beat each, out_last=1 on both, and in_ready=1 every cycle with out_ready=1.
